// File: rtl/pump_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pump_pkg : shared channel state encoding and sizing constants     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package pump_pkg;

  localparam int MAX_CH = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PEND = 2'd2,
    ST_ON   = 2'd3
  } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/pump_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pump_channel : per-channel FSM, edge detect and seconds timer     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pump_channel
  import pump_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             force_i,
  input  logic             abort_i,
  input  logic             grant_i,
  input  logic [CNT_W-1:0] period_s_i,
  input  logic [CNT_W-1:0] on_s_i,
  output ch_state_t        state_o,
  output logic             req_o,
  output logic             done_o
);

  localparam int               PRE_W    = $clog2(CLOCK_FREQ);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLOCK_FREQ - 1);

  ch_state_t        state_q, state_d;
  logic             en_q, frc_q;
  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] sec_q, lim_q, lim_d, lim_src;
  logic             en_rise, frc_rise, expire, to_pend, load;

  assign en_rise  = enable_i & ~en_q;
  assign frc_rise = force_i & ~frc_q;
  assign expire   = (pre_q == PRE_LAST) && (sec_q == lim_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    to_pend = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frc_rise)     to_pend = 1'b1;
        else if (en_rise) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (frc_rise)       to_pend = 1'b1;
        else if (!enable_i) state_d = ST_IDLE;
        else if (expire)    to_pend = 1'b1;
      end
      ST_ON: begin
        if (expire) begin
          done_o  = 1'b1;
          state_d = enable_i ? ST_WAIT : ST_IDLE;
        end
      end
      default: ;
    endcase
    if (to_pend) state_d = ST_PEND;
    // A request granted in the cycle it arises goes straight to ON
    req_o = !abort_i && (to_pend || state_q == ST_PEND);
    if (grant_i) state_d = ST_ON;
    if (abort_i) state_d = ST_IDLE;

    load    = (state_d != state_q) && (state_d == ST_WAIT || state_d == ST_ON);
    lim_src = (state_d == ST_ON) ? on_s_i : period_s_i;
    lim_d   = (lim_src == '0) ? CNT_W'(1) : lim_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      frc_q   <= 1'b0;
      pre_q   <= '0;
      sec_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= enable_i;
      frc_q   <= force_i;
      if (load) begin
        pre_q <= '0;
        sec_q <= '0;
        lim_q <= lim_d;
      end else if (state_q == ST_WAIT || state_q == ST_ON) begin
        if (pre_q == PRE_LAST) begin
          pre_q <= '0;
          sec_q <= sec_q + CNT_W'(1);
        end else begin
          pre_q <= pre_q + PRE_W'(1);
        end
      end
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/pump_scheduler_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pump_scheduler_multi : round-robin pump arbiter with dead time    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pump_scheduler_multi
  import pump_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_enable_i,
  input  logic [NUM_CH*CNT_W-1:0] period_s_i,
  input  logic [NUM_CH*CNT_W-1:0] on_s_i,
  input  logic [NUM_CH-1:0]       force_i,
  input  logic                    abort_all_i,
  output logic [NUM_CH-1:0]       pump_out_o,
  output logic [IDX_W-1:0]        active_ch_o,
  output logic                    busy_o,
  output logic [NUM_CH-1:0]       pend_mask_o
);

  localparam logic [7:0] DEAD_M1 = 8'(DEAD_CYC - 1);

  ch_state_t         ch_state [NUM_CH];
  logic [NUM_CH-1:0] req, done, on_mask, grant, req_rot;
  logic [NUM_CH-1:0] pump_out_q, pump_out_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d, active_q, active_d, gidx;
  logic [7:0]        dead_q, dead_d;
  logic              busy_q, busy_d, found;
  int                arb_idx, nxt_ptr;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pump_channel #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .CNT_W      (CNT_W)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (ch_enable_i[i]),
        .force_i    (force_i[i]),
        .abort_i    (abort_all_i),
        .grant_i    (grant[i]),
        .period_s_i (period_s_i[i*CNT_W +: CNT_W]),
        .on_s_i     (on_s_i[i*CNT_W +: CNT_W]),
        .state_o    (ch_state[i]),
        .req_o      (req[i]),
        .done_o     (done[i])
      );
      assign on_mask[i]     = (ch_state[i] == ST_ON);
      assign pend_mask_o[i] = (ch_state[i] == ST_PEND);
    end
  endgenerate

  always_comb begin
    found   = 1'b0;
    gidx    = '0;
    arb_idx = 0;
    req_rot = '0;
    // Grant only into a fully idle bus whose dead time has elapsed
    if (!abort_all_i && on_mask == '0 && dead_q == '0) begin
      for (int k = 0; k < MAX_CH; k++) begin
        if (k < NUM_CH && !found) begin
          arb_idx = int'(ptr_q) + k;
          if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
          req_rot = req >> arb_idx;
          if (req_rot[0]) begin
            found = 1'b1;
            gidx  = IDX_W'(arb_idx);
          end
        end
      end
    end
    grant   = found ? (NUM_CH'(1) << gidx) : '0;
    nxt_ptr = int'(gidx) + 1;
    if (nxt_ptr >= NUM_CH) nxt_ptr = 0;
    ptr_d   = found ? IDX_W'(nxt_ptr) : ptr_q;

    pump_out_d = abort_all_i ? '0 : (grant | (on_mask & ~done));
    if (pump_out_d == '0) active_d = '0;
    else if (found)       active_d = gidx;
    else                  active_d = active_q;
    busy_d = |pump_out_d;

    // Loading DEAD_CYC-1 lets the grant land in the last required off cycle
    if ((pump_out_q & ~pump_out_d) != '0) dead_d = DEAD_M1;
    else if (dead_q != '0)                dead_d = dead_q - 8'd1;
    else                                  dead_d = dead_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pump_out_q <= '0;
      active_q   <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      dead_q     <= '0;
    end else begin
      pump_out_q <= pump_out_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      dead_q     <= dead_d;
    end
  end

  assign pump_out_o  = pump_out_q;
  assign active_ch_o = active_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire
